// File: rtl/subtract_divider.sv
// Sequential 8-bit unsigned restoring divider. One quotient bit is produced per clock,
// and every trial subtraction goes through a single shared SUBTRACTION instance.

module SUBTRACTION (
  input  logic [7:0] A,
  input  logic [7:0] B,
  output logic [7:0] F
);
  logic [7:0] b_inv;

  // Two's-complement subtraction: invert B, add one, then add to A.
  assign b_inv = ~B;
  assign F     = A + b_inv + 8'd1;
endmodule

module subtract_divider (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] dividend,
  input  logic [7:0] divisor,
  output logic       busy,
  output logic       done,
  output logic [7:0] quotient,
  output logic [7:0] remainder,
  output logic       div_by_zero
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t     state;
  logic [7:0] d_reg;
  logic [7:0] q_reg;
  logic [8:0] r_reg;
  logic [2:0] cnt;

  logic [8:0] trial;
  logic [7:0] diff;
  logic       accept;
  logic [8:0] r_next;
  logic [7:0] q_next;

  assign trial = {r_reg[7:0], q_reg[7]};

  SUBTRACTION u_sub (
    .A(trial[7:0]),
    .B(d_reg),
    .F(diff)
  );

  // SUBTRACTION has no borrow output, so acceptance is decided by a 9-bit
  // compare. The partial remainder stays below D, so the true difference
  // always fits in the subtractor's 8-bit result.
  always_comb begin
    accept = (trial >= {1'b0, d_reg});
    r_next = accept ? {1'b0, diff} : trial;
    q_next = {q_reg[6:0], accept};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      d_reg       <= 8'd0;
      q_reg       <= 8'd0;
      r_reg       <= 9'd0;
      cnt         <= 3'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= 8'd0;
      remainder   <= 8'd0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            d_reg <= divisor;
            q_reg <= dividend;
            r_reg <= 9'd0;
            cnt   <= 3'd0;
            if (divisor == 8'd0) begin
              state       <= DONE;
              done        <= 1'b1;
              quotient    <= 8'hFF;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              state       <= RUN;
              busy        <= 1'b1;
              quotient    <= 8'd0;
              remainder   <= 8'd0;
              div_by_zero <= 1'b0;
            end
          end
        end
        RUN: begin
          r_reg <= r_next;
          q_reg <= q_next;
          cnt   <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            state       <= DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            quotient    <= q_next;
            remainder   <= r_next[7:0];
            div_by_zero <= 1'b0;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end
endmodule
